// File: rtl/axis_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axis_bus_arbiter
//  Description : Packet-level round-robin arbiter for the 4-to-1 AXI-Stream
//                FIFO mux/demux path. It grants one FIFO at a time, holds the
//                grant until that FIFO's tlast beat is accepted, then inserts
//                a one-cycle idle gap and rotates priority.
//                Optional stall timeout: define AXIS_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_bus_arbiter #(
    parameter int          NUM_CH         = 4,
    parameter logic [7:0]  SEL_BASE       = 8'd128,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arb_en,
    input  logic [NUM_CH-1:0] axis_fifo_tvalid,
    input  logic [NUM_CH-1:0] axis_fifo_tlast,
    input  logic              axis_in_tready,
    output logic [7:0]        bus_sel,
    output logic              grant_valid,
    output logic [1:0]        grant_ch,
    output logic              pkt_done,
    output logic [15:0]       pkt_count,
    output logic              timeout_err
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_GRANT = 1'b1;

    logic [0:0] r_state;
    logic [1:0] r_ptr;       // last channel served
    logic       w_pick_valid;
    logic [1:0] w_pick_ch;
    logic [1:0] w_idx;
    logic       w_beat;
    logic       w_last_beat;
    logic       w_abort;

    // Beat on the granted channel; grant_ch is only meaningful in GRANT
    assign w_beat      = axis_fifo_tvalid[grant_ch] && axis_in_tready;
    assign w_last_beat = w_beat && axis_fifo_tlast[grant_ch];

    // Round-robin search: first requesting channel after the last one served
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_ch    = r_ptr;
        w_idx        = 2'd0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_pick_valid && axis_fifo_tvalid[w_idx]) begin
                w_pick_valid = 1'b1;
                w_pick_ch    = w_idx;
            end
        end
    end

`ifdef AXIS_ARB_TIMEOUT_EN
    logic [15:0] r_stall_cnt;

    // Abort a grant once the stall counter has sat at the limit without a beat
    assign w_abort = (r_state == c_ST_GRANT) && !w_beat && (r_stall_cnt == TIMEOUT_CYCLES);

    // Stall counter: counts non-beat cycles in GRANT, cleared on beats and outside GRANT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            if (r_state != c_ST_GRANT || w_beat) begin
                r_stall_cnt <= 16'd0;
            end else if (w_abort) begin
                r_stall_cnt <= 16'd0;
                timeout_err <= 1'b1;
            end else begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end
`else
    logic w_unused_timeout;

    assign w_abort          = 1'b0;
    assign timeout_err      = 1'b0;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Arbitration state machine and registered select outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_ptr       <= 2'd3;
            bus_sel     <= 8'd0;
            grant_valid <= 1'b0;
            grant_ch    <= 2'd0;
            pkt_done    <= 1'b0;
            pkt_count   <= 16'd0;
        end else begin
            pkt_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (arb_en && w_pick_valid) begin
                        r_state     <= c_ST_GRANT;
                        bus_sel     <= SEL_BASE + {6'd0, w_pick_ch};
                        grant_valid <= 1'b1;
                        grant_ch    <= w_pick_ch;
                    end else begin
                        bus_sel     <= 8'd0;
                        grant_valid <= 1'b0;
                    end
                end
                c_ST_GRANT: begin
                    // Release on packet end or timeout; the IDLE cycle that
                    // follows forms the mandatory gap between packets
                    if (w_last_beat) begin
                        r_state     <= c_ST_IDLE;
                        r_ptr       <= grant_ch;
                        bus_sel     <= 8'd0;
                        grant_valid <= 1'b0;
                        pkt_done    <= 1'b1;
                        pkt_count   <= pkt_count + 16'd1;
                    end else if (w_abort) begin
                        r_state     <= c_ST_IDLE;
                        r_ptr       <= grant_ch;
                        bus_sel     <= 8'd0;
                        grant_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    bus_sel     <= 8'd0;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_bus_arbiter
//  Description : Self-checking bench for axis_bus_arbiter: directed scenarios
//                plus randomized traffic against a packet-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axis_bus_arbiter;

    localparam int c_TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arb_en = 1'b0;
    logic [3:0]  tvalid = 4'd0;
    logic [3:0]  tlast = 4'd0;
    logic        tready = 1'b0;
    logic [7:0]  bus_sel;
    logic        grant_valid;
    logic [1:0]  grant_ch;
    logic        pkt_done;
    logic [15:0] pkt_count;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    axis_bus_arbiter #(
        .NUM_CH         (4),
        .SEL_BASE       (8'd128),
        .TIMEOUT_CYCLES (16'(c_TO))
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .arb_en           (arb_en),
        .axis_fifo_tvalid (tvalid),
        .axis_fifo_tlast  (tlast),
        .axis_in_tready   (tready),
        .bus_sel          (bus_sel),
        .grant_valid      (grant_valid),
        .grant_ch         (grant_ch),
        .pkt_done         (pkt_done),
        .pkt_count        (pkt_count),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (packet-level) ----------------
    int          m_gch   = -1;   // granted channel, -1 when idle
    int          m_last  = 3;    // last served channel
    int          m_stall = 0;
    logic [1:0]  m_gout  = 2'd0;
    logic        m_done  = 1'b0;
    logic        m_tout  = 1'b0;
    logic [15:0] m_cnt   = 16'd0;

    function automatic int rr_pick(input int last, input logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [7:0] m_sel();
        return (m_gch < 0) ? 8'd0 : 8'(128 + m_gch);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_gch <= -1; m_last <= 3; m_stall <= 0; m_gout <= 2'd0;
            m_done <= 1'b0; m_tout <= 1'b0; m_cnt <= 16'd0;
        end else begin
            m_done <= 1'b0;
            m_tout <= 1'b0;
            if (m_gch < 0) begin
                m_stall <= 0;
                if (arb_en && tvalid != 4'd0) begin
                    m_gch  <= rr_pick(m_last, tvalid);
                    m_gout <= 2'(rr_pick(m_last, tvalid));
                end
            end else if (tvalid[m_gch] && tready) begin
                m_stall <= 0;
                if (tlast[m_gch]) begin
                    m_gch <= -1; m_last <= m_gch; m_done <= 1'b1; m_cnt <= m_cnt + 16'd1;
                end
            end else begin
`ifdef AXIS_ARB_TIMEOUT_EN
                if (m_stall == c_TO) begin
                    m_gch <= -1; m_last <= m_gch; m_tout <= 1'b1; m_stall <= 0;
                end else begin
                    m_stall <= m_stall + 1;
                end
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; arb_en = 1'b0; tvalid = 4'd0; tlast = 4'd0; tready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; tick();
        n_checks++;
        if ({bus_sel, grant_valid, grant_ch, pkt_done, pkt_count, timeout_err} !== 29'd0) begin
            n_errors++;
            $display("FAIL reset_values got sel=%0d gv=%0d ch=%0d done=%0d cnt=%0d to=%0d want all 0",
                     bus_sel, grant_valid, grant_ch, pkt_done, pkt_count, timeout_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        arb_en = 1'b1; tvalid = 4'b0100; tready = 1'b1; tlast = 4'd0;
        tick();
        n_checks++;
        if (bus_sel !== 8'd130 || grant_valid !== 1'b1 || grant_ch !== 2'd2) begin
            n_errors++;
            $display("FAIL single_grant got sel=%0d gv=%0d ch=%0d want 130 1 2", bus_sel, grant_valid, grant_ch);
        end
        tick(); tick();
        tlast = 4'b0100;
        tick();
        n_checks++;
        if (bus_sel !== 8'd0 || pkt_done !== 1'b1 || pkt_count !== 16'd1) begin
            n_errors++;
            $display("FAIL single_done got sel=%0d done=%0d cnt=%0d want 0 1 1", bus_sel, pkt_done, pkt_count);
        end
        tvalid = 4'd0; tlast = 4'd0;
        tick();
        n_checks++;
        if (pkt_done !== 1'b0 || pkt_count !== 16'd1) begin
            n_errors++;
            $display("FAIL single_pulse got done=%0d cnt=%0d want 0 1", pkt_done, pkt_count);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] exp_seq [9];
        exp_seq = '{8'd128, 8'd0, 8'd129, 8'd0, 8'd130, 8'd0, 8'd131, 8'd0, 8'd128};
        do_reset();
        arb_en = 1'b1; tvalid = 4'b1111; tlast = 4'b1111; tready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            n_checks++;
            if (bus_sel !== exp_seq[i]) begin
                n_errors++;
                $display("FAIL rotation_step%0d got sel=%0d want %0d", i, bus_sel, exp_seq[i]);
            end
        end
        tick();
        n_checks++;
        if (pkt_count !== 16'd5 || bus_sel !== 8'd0) begin
            n_errors++;
            $display("FAIL rotation_count got cnt=%0d sel=%0d want 5 0", pkt_count, bus_sel);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        arb_en = 1'b1; tvalid = 4'b0010; tlast = 4'd0; tready = 1'b1;
        tick();
        n_checks++;
        if (bus_sel !== 8'd129) begin
            n_errors++;
            $display("FAIL bp_grant got sel=%0d want 129", bus_sel);
        end
        tick();
        tready = 1'b0; tlast = 4'b0010;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_sel !== 8'd129 || pkt_done !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL bp_hold got %0d bad cycles (last sel=%0d) want 0", bad, bus_sel);
        end
        tready = 1'b1;
        tick();
        n_checks++;
        if (bus_sel !== 8'd0 || pkt_done !== 1'b1 || pkt_count !== 16'd1) begin
            n_errors++;
            $display("FAIL bp_release got sel=%0d done=%0d cnt=%0d want 0 1 1", bus_sel, pkt_done, pkt_count);
        end
    endtask

    task automatic test_arb_en_drop();
        int bad;
        do_reset();
        arb_en = 1'b1; tvalid = 4'b0001; tlast = 4'd0; tready = 1'b1;
        tick();
        arb_en = 1'b0; tvalid = 4'b1111;
        tick(); tick();
        n_checks++;
        if (bus_sel !== 8'd128) begin
            n_errors++;
            $display("FAIL en_drop_hold got sel=%0d want 128", bus_sel);
        end
        tlast = 4'b1111;
        tick();
        n_checks++;
        if (bus_sel !== 8'd0 || pkt_done !== 1'b1) begin
            n_errors++;
            $display("FAIL en_drop_complete got sel=%0d done=%0d want 0 1", bus_sel, pkt_done);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus_sel !== 8'd0 || grant_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL en_drop_idle got %0d granted cycles want 0", bad);
        end
        arb_en = 1'b1; tlast = 4'd0;
        tick();
        n_checks++;
        if (bus_sel !== 8'd129 || grant_ch !== 2'd1) begin
            n_errors++;
            $display("FAIL en_drop_next got sel=%0d ch=%0d want 129 1", bus_sel, grant_ch);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        arb_en = 1'b1; tready = 1'b1; tvalid = 4'b0100; tlast = 4'b0100;
        tick(); tick();               // ch2 packet completes, last served = 2
        tvalid = 4'b1000; tlast = 4'd0;
        tick();
        n_checks++;
        if (bus_sel !== 8'd131) begin
            n_errors++;
            $display("FAIL rst_mid_grant got sel=%0d want 131", bus_sel);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus_sel !== 8'd0 || pkt_count !== 16'd0 || grant_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_clear got sel=%0d cnt=%0d gv=%0d want 0 0 0", bus_sel, pkt_count, grant_valid);
        end
        tvalid = 4'b1001;
        tick();
        n_checks++;
        if (bus_sel !== 8'd128 || grant_ch !== 2'd0) begin
            n_errors++;
            $display("FAIL rst_mid_next got sel=%0d ch=%0d want 128 0", bus_sel, grant_ch);
        end
    endtask

    task automatic test_timeout();
        int bad;
        int seen;
        int first;
        do_reset();
        arb_en = 1'b1; tvalid = 4'b0100; tlast = 4'd0; tready = 1'b1;
        tick();
        n_checks++;
        if (bus_sel !== 8'd130) begin
            n_errors++;
            $display("FAIL to_grant got sel=%0d want 130", bus_sel);
        end
        tvalid = 4'd0;
        bad = 0; seen = 0; first = -1;
`ifdef AXIS_ARB_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            tick();
            if (timeout_err === 1'b1) begin
                seen++;
                if (first < 0) first = i;
            end
        end
        n_checks++;
        if (seen != 1 || first < 7 || first > 9) begin
            n_errors++;
            $display("FAIL to_pulse got pulses=%0d at=%0d want 1 at 7..9", seen, first);
        end
        n_checks++;
        if (bus_sel !== 8'd0 || grant_valid !== 1'b0 || pkt_count !== 16'd0) begin
            n_errors++;
            $display("FAIL to_release got sel=%0d gv=%0d cnt=%0d want 0 0 0", bus_sel, grant_valid, pkt_count);
        end
`else
        for (int i = 0; i < 120; i++) begin
            tick();
            if (bus_sel !== 8'd130 || timeout_err !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL to_hold got %0d bad cycles (sel=%0d to=%0d) want 0", bad, bus_sel, timeout_err);
        end
        tvalid = 4'b0100; tlast = 4'b0100;
        tick();
        n_checks++;
        if (pkt_done !== 1'b1 || pkt_count !== 16'd1 || bus_sel !== 8'd0) begin
            n_errors++;
            $display("FAIL to_finish got done=%0d cnt=%0d sel=%0d want 1 1 0", pkt_done, pkt_count, bus_sel);
        end
`endif
        tvalid = 4'd0; tlast = 4'd0;
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (bus_sel !== m_sel() || grant_valid !== (m_gch >= 0) || grant_ch !== m_gout ||
                pkt_done !== m_done || pkt_count !== m_cnt || timeout_err !== m_tout) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL random_cycle%0d got sel=%0d gv=%0d ch=%0d done=%0d cnt=%0d to=%0d want %0d %0d %0d %0d %0d %0d",
                             i, bus_sel, grant_valid, grant_ch, pkt_done, pkt_count, timeout_err,
                             m_sel(), (m_gch >= 0), m_gout, m_done, m_cnt, m_tout);
            end
            rst    = ($urandom_range(0, 249) == 0);
            arb_en = ($urandom_range(0, 9) != 0);
            tvalid = 4'($urandom);
            tlast  = 4'($urandom) & 4'($urandom);
            tready = ($urandom_range(0, 3) != 0);
        end
        rst = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL random_model got %0d mismatching cycles want 0", bad);
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_arb_en_drop();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
